// File: rtl/keypad_event_filter.sv
// keypad_event_filter
// Turns raw keypad scanner output into clean key events. A press or a
// release is accepted only after it has been stable for DEBOUNCE_CYC
// cycles. Each accepted press gives one key_valid strobe. Keys whose bit
// is set in repeat_mask also give auto-repeat strobes: the first one
// REPEAT_DELAY cycles after the press, then one every REPEAT_PERIOD
// cycles. All outputs are registered.

module keypad_event_filter #(
  parameter int DEBOUNCE_CYC  = 2000,
  parameter int REPEAT_DELAY  = 40000,
  parameter int REPEAT_PERIOD = 10000,
  parameter int CNT_W         = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_in,
  input  logic        pressed_in,
  input  logic [15:0] repeat_mask,
  output logic [3:0]  key_evt,
  output logic        key_valid,
  output logic        key_repeat,
  output logic        key_held
);

  // Terminal counts. Counters only ever compare for equality, so they
  // never wrap.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEB_PRESS,
    S_HOLD,
    S_REPEAT,
    S_DEB_REL
  } state_t;

  // Synchronised scanner inputs. The FSM looks only at these.
  logic [3:0]       key_s;
  logic             pressed_s;

  state_t           state_reg, state_next;
  logic [3:0]       cand_key_reg, cand_key_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [3:0]       key_evt_reg, key_evt_next;
  logic             key_valid_reg, key_valid_next;
  logic             key_repeat_reg, key_repeat_next;
  logic             key_held_reg, key_held_next;

  // The candidate key has been let go, or a different key has appeared.
  logic             key_lost;
  // Auto-repeat is enabled for the candidate key.
  logic             repeat_en;
  logic [15:0]      key_onehot;

  // Decode the candidate key to one-hot so it can be ANDed with repeat_mask.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_key_dec
      assign key_onehot[gi] = (cand_key_reg == 4'(gi));
    end
  endgenerate

  assign repeat_en = |(repeat_mask & key_onehot);
  assign key_lost  = !pressed_s || (key_s != cand_key_reg);

  // Register the scanner outputs once before the FSM uses them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s     <= 4'd0;
      pressed_s <= 1'b0;
    end else begin
      key_s     <= key_in;
      pressed_s <= pressed_in;
    end
  end

  // State, candidate key, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      cand_key_reg   <= 4'd0;
      cnt_reg        <= '0;
      key_evt_reg    <= 4'd0;
      key_valid_reg  <= 1'b0;
      key_repeat_reg <= 1'b0;
      key_held_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cand_key_reg   <= cand_key_next;
      cnt_reg        <= cnt_next;
      key_evt_reg    <= key_evt_next;
      key_valid_reg  <= key_valid_next;
      key_repeat_reg <= key_repeat_next;
      key_held_reg   <= key_held_next;
    end
  end

  // Next-state logic: debounce, hold/repeat timing and event generation.
  always_comb begin
    state_next      = state_reg;
    cand_key_next   = cand_key_reg;
    cnt_next        = cnt_reg;
    key_evt_next    = key_evt_reg;
    key_valid_next  = 1'b0;
    key_repeat_next = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (pressed_s) begin
          cand_key_next = key_s;
          cnt_next      = '0;
          state_next    = S_DEB_PRESS;
        end
      end

      S_DEB_PRESS: begin
        if (key_lost) begin
          // Bounce or glitch: drop the candidate without an event.
          cnt_next   = '0;
          state_next = S_IDLE;
        end else if (cnt_reg == DEB_LAST) begin
          key_evt_next   = cand_key_reg;
          key_valid_next = 1'b1;
          cnt_next       = '0;
          state_next     = S_HOLD;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (key_lost) begin
          // A new key must wait for a full release before it counts.
          cnt_next   = '0;
          state_next = S_DEB_REL;
        end else if (!repeat_en) begin
          cnt_next = '0;
        end else if (cnt_reg == DLY_LAST) begin
          key_evt_next    = cand_key_reg;
          key_valid_next  = 1'b1;
          key_repeat_next = 1'b1;
          cnt_next        = '0;
          state_next      = S_REPEAT;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      S_REPEAT: begin
        if (key_lost) begin
          cnt_next   = '0;
          state_next = S_DEB_REL;
        end else if (!repeat_en) begin
          // Repeat was disabled for this key while it was held.
          cnt_next   = '0;
          state_next = S_HOLD;
        end else if (cnt_reg == PER_LAST) begin
          key_evt_next    = cand_key_reg;
          key_valid_next  = 1'b1;
          key_repeat_next = 1'b1;
          cnt_next        = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      S_DEB_REL: begin
        if (pressed_s) begin
          // Release bounce: restart the release window.
          cnt_next = '0;
        end else if (cnt_reg == DEB_LAST) begin
          cnt_next   = '0;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        cnt_next   = '0;
        state_next = S_IDLE;
      end
    endcase

    key_held_next = (state_next == S_HOLD) || (state_next == S_REPEAT);
  end

  assign key_evt    = key_evt_reg;
  assign key_valid  = key_valid_reg;
  assign key_repeat = key_repeat_reg;
  assign key_held   = key_held_reg;

endmodule

// File: tb/tb_keypad_event_filter.sv
// tb_keypad_event_filter
// Directed bench for keypad_event_filter with DEBOUNCE_CYC=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=5. Cycle k of a scenario means that
// inputs are driven just before rising edge k and outputs are sampled
// 1 ns after that edge.

module tb_keypad_event_filter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  key_in;
  logic        pressed_in;
  logic [15:0] repeat_mask;
  logic [3:0]  key_evt;
  logic        key_valid;
  logic        key_repeat;
  logic        key_held;

  int n_checks = 0;
  int n_pass   = 0;

  keypad_event_filter #(
    .DEBOUNCE_CYC (4),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(5),
    .CNT_W        (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .pressed_in (pressed_in),
    .repeat_mask(repeat_mask),
    .key_evt    (key_evt),
    .key_valid  (key_valid),
    .key_repeat (key_repeat),
    .key_held   (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [0:13] bounce_pat;
    logic        exp_v;

    rst_n       = 1'b0;
    key_in      = 4'd0;
    pressed_in  = 1'b0;
    repeat_mask = 16'h0000;
    #1;
    check("reset_evt",    key_evt,    4'd0);
    check("reset_valid",  key_valid,  1'b0);
    check("reset_repeat", key_repeat, 1'b0);
    check("reset_held",   key_held,   1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_valid", key_valid, 1'b0);

    // Clean press of key 5, held for 8 samples, no repeat.
    for (int k = 1; k <= 16; k++) begin
      key_in     = 4'd5;
      pressed_in = (k <= 8);
      tick();
      check($sformatf("clean_valid_k%0d", k), key_valid, (k == 6));
      check($sformatf("clean_held_k%0d", k), key_held, (k >= 6 && k <= 9));
      if (k == 6) begin
        check("clean_evt", key_evt, 4'd5);
        check("clean_repeat", key_repeat, 1'b0);
      end
    end
    check("clean_evt_holds", key_evt, 4'd5);
    $display("scenario clean press done");

    // Bounce 1,1,0,1,1,0 then stable for 8 samples: one event at cycle 12.
    bounce_pat = 14'b11011011111111;
    for (int k = 1; k <= 22; k++) begin
      key_in     = 4'd9;
      pressed_in = (k <= 14) ? bounce_pat[k-1] : 1'b0;
      tick();
      check($sformatf("bounce_valid_k%0d", k), key_valid, (k == 12));
      check($sformatf("bounce_held_k%0d", k), key_held, (k >= 12 && k <= 15));
      if (k == 12) check("bounce_evt", key_evt, 4'd9);
    end
    $display("scenario bounce done");

    // Auto-repeat on key 2: press at 6, repeats at 16,21,...,41.
    repeat_mask = 16'h0004;
    for (int k = 1; k <= 50; k++) begin
      key_in     = 4'd2;
      pressed_in = (k <= 40);
      tick();
      exp_v = (k == 6) || (k >= 16 && k <= 41 && ((k - 16) % 5 == 0));
      check($sformatf("rep_valid_k%0d", k), key_valid, exp_v);
      check($sformatf("rep_repeat_k%0d", k), key_repeat, exp_v && (k != 6));
      check($sformatf("rep_held_k%0d", k), key_held, (k >= 6 && k <= 41));
      if (exp_v) check($sformatf("rep_evt_k%0d", k), key_evt, 4'd2);
    end
    $display("scenario auto-repeat done");

    // Same key with repeat disabled: a single press event.
    repeat_mask = 16'h0000;
    for (int k = 1; k <= 50; k++) begin
      key_in     = 4'd2;
      pressed_in = (k <= 40);
      tick();
      check($sformatf("mask_valid_k%0d", k), key_valid, (k == 6));
      check($sformatf("mask_repeat_k%0d", k), key_repeat, 1'b0);
      check($sformatf("mask_held_k%0d", k), key_held, (k >= 6 && k <= 41));
    end
    $display("scenario masked key done");

    // Key 3 pressed, then switched to 7 while still down: no event for 7.
    for (int k = 1; k <= 40; k++) begin
      key_in     = (k <= 11) ? 4'd3 : 4'd7;
      pressed_in = (k <= 31);
      tick();
      check($sformatf("chg_valid_k%0d", k), key_valid, (k == 6));
      check($sformatf("chg_held_k%0d", k), key_held, (k >= 6 && k <= 12));
      if (k == 6) check("chg_evt3", key_evt, 4'd3);
    end
    // After the full release, key 7 is accepted as a fresh press.
    for (int k = 1; k <= 8; k++) begin
      key_in     = 4'd7;
      pressed_in = 1'b1;
      tick();
      check($sformatf("chg7_valid_k%0d", k), key_valid, (k == 6));
      if (k == 6) check("chg_evt7", key_evt, 4'd7);
    end
    pressed_in = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    $display("scenario key change done");

    // Reset asserted while repeating; key stays down across reset.
    repeat_mask = 16'h0004;
    for (int k = 1; k <= 18; k++) begin
      key_in     = 4'd2;
      pressed_in = 1'b1;
      tick();
    end
    check("pre_rst_held", key_held, 1'b1);
    check("pre_rst_evt",  key_evt,  4'd2);
    rst_n = 1'b0;
    #1;
    check("rst_evt",    key_evt,    4'd0);
    check("rst_valid",  key_valid,  1'b0);
    check("rst_repeat", key_repeat, 1'b0);
    check("rst_held",   key_held,   1'b0);
    tick();
    tick();
    check("rst_hold_valid", key_valid, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("post_rst_valid_k%0d", k), key_valid, (k == 6));
      check($sformatf("post_rst_held_k%0d", k), key_held, (k >= 6));
      if (k == 6) check("post_rst_evt", key_evt, 4'd2);
    end
    pressed_in = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    $display("scenario reset done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
